// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling and a bubble counter.
// Optional feature macro: HAZARD_DET_EN (load-use detection and bubble insertion).
module id_ex_pipe #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  hold_i,
    input  logic                  flush_i,
    input  logic                  id_valid,
    input  logic                  RegDest,
    input  logic                  SaltoCond,
    input  logic                  LeerMem,
    input  logic                  MemaReg,
    input  logic                  EscrMem,
    input  logic                  FuenteALU,
    input  logic                  EscrReg,
    input  logic [1:0]            ALUOp,
    input  logic [DATA_W-1:0]     pc4_id,
    input  logic [DATA_W-1:0]     rd1_id,
    input  logic [DATA_W-1:0]     rd2_id,
    input  logic [DATA_W-1:0]     imm_id,
    input  logic [REG_ADDR_W-1:0] rs_id,
    input  logic [REG_ADDR_W-1:0] rt_id,
    input  logic [REG_ADDR_W-1:0] rd_id,
    output logic                  RegDest_ex,
    output logic                  SaltoCond_ex,
    output logic                  LeerMem_ex,
    output logic                  MemaReg_ex,
    output logic                  EscrMem_ex,
    output logic                  FuenteALU_ex,
    output logic                  EscrReg_ex,
    output logic [1:0]            ALUOp_ex,
    output logic [DATA_W-1:0]     pc4_id_ex,
    output logic [DATA_W-1:0]     rd1_id_ex,
    output logic [DATA_W-1:0]     rd2_id_ex,
    output logic [DATA_W-1:0]     imm_id_ex,
    output logic [REG_ADDR_W-1:0] rs_id_ex,
    output logic [REG_ADDR_W-1:0] rt_id_ex,
    output logic [REG_ADDR_W-1:0] rd_id_ex,
    output logic                  ex_valid,
    output logic                  stall_o,
    output logic [CNT_W-1:0]      bubble_cnt
);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] val);
        if (val == {CNT_W{1'b1}}) begin
            return val;
        end else begin
            return val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    logic hazardHit;

`ifdef HAZARD_DET_EN
    // Load in EX whose destination rt feeds a source of the instruction in ID
    always_comb begin
        hazardHit = 1'b0;
        if (LeerMem_ex && ex_valid && id_valid && (rt_id_ex != {REG_ADDR_W{1'b0}})) begin
            hazardHit = (rt_id_ex == rs_id) || (rt_id_ex == rt_id);
        end else begin
            hazardHit = 1'b0;
        end
    end
`else
    assign hazardHit = 1'b0;
`endif

    // A flush kills the ID instruction anyway, so no stall is requested for it
    always_comb begin
        stall_o = 1'b0;
        if (flush_i) begin
            stall_o = 1'b0;
        end else begin
            stall_o = hazardHit;
        end
    end

    // Pipeline register: flush > hold > bubble > normal load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            RegDest_ex   <= 1'b0;
            SaltoCond_ex <= 1'b0;
            LeerMem_ex   <= 1'b0;
            MemaReg_ex   <= 1'b0;
            EscrMem_ex   <= 1'b0;
            FuenteALU_ex <= 1'b0;
            EscrReg_ex   <= 1'b0;
            ALUOp_ex     <= 2'b00;
            pc4_id_ex    <= {DATA_W{1'b0}};
            rd1_id_ex    <= {DATA_W{1'b0}};
            rd2_id_ex    <= {DATA_W{1'b0}};
            imm_id_ex    <= {DATA_W{1'b0}};
            rs_id_ex     <= {REG_ADDR_W{1'b0}};
            rt_id_ex     <= {REG_ADDR_W{1'b0}};
            rd_id_ex     <= {REG_ADDR_W{1'b0}};
            ex_valid     <= 1'b0;
            bubble_cnt   <= {CNT_W{1'b0}};
        end else if (hold_i && !flush_i) begin
            RegDest_ex   <= RegDest_ex;
            SaltoCond_ex <= SaltoCond_ex;
            LeerMem_ex   <= LeerMem_ex;
            MemaReg_ex   <= MemaReg_ex;
            EscrMem_ex   <= EscrMem_ex;
            FuenteALU_ex <= FuenteALU_ex;
            EscrReg_ex   <= EscrReg_ex;
            ALUOp_ex     <= ALUOp_ex;
            pc4_id_ex    <= pc4_id_ex;
            rd1_id_ex    <= rd1_id_ex;
            rd2_id_ex    <= rd2_id_ex;
            imm_id_ex    <= imm_id_ex;
            rs_id_ex     <= rs_id_ex;
            rt_id_ex     <= rt_id_ex;
            rd_id_ex     <= rd_id_ex;
            ex_valid     <= ex_valid;
            bubble_cnt   <= bubble_cnt;
        end else begin
            pc4_id_ex <= pc4_id;
            rd1_id_ex <= rd1_id;
            rd2_id_ex <= rd2_id;
            imm_id_ex <= imm_id;
            rs_id_ex  <= rs_id;
            rt_id_ex  <= rt_id;
            rd_id_ex  <= rd_id;
            if (flush_i || stall_o) begin
                RegDest_ex   <= 1'b0;
                SaltoCond_ex <= 1'b0;
                LeerMem_ex   <= 1'b0;
                MemaReg_ex   <= 1'b0;
                EscrMem_ex   <= 1'b0;
                FuenteALU_ex <= 1'b0;
                EscrReg_ex   <= 1'b0;
                ALUOp_ex     <= 2'b00;
                ex_valid     <= 1'b0;
                bubble_cnt   <= satInc(bubble_cnt);
            end else begin
                // An empty ID slot must never carry live control into EX
                RegDest_ex   <= RegDest   & id_valid;
                SaltoCond_ex <= SaltoCond & id_valid;
                LeerMem_ex   <= LeerMem   & id_valid;
                MemaReg_ex   <= MemaReg   & id_valid;
                EscrMem_ex   <= EscrMem   & id_valid;
                FuenteALU_ex <= FuenteALU & id_valid;
                EscrReg_ex   <= EscrReg   & id_valid;
                ALUOp_ex     <= ALUOp & {2{id_valid}};
                ex_valid     <= id_valid;
                bubble_cnt   <= bubble_cnt;
            end
        end
    end

endmodule
